// File: rtl/axilite_wb_master_pkg.sv
// rtl/axilite_wb_master_pkg.sv - shared types and defaults for the AXI-Lite to Wishbone bridge
package axilite_wb_master_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_CYC,
        WR_DONE,
        RD_CYC,
        RD_DONE
    } state_e;

    localparam logic [31:0] DEF_BASE_ADDR = 32'h3000_0000;
    localparam int unsigned DEF_TIMEOUT   = 255;
    localparam logic [31:0] DEF_TO_DATA   = 32'hDEAD_BEEF;

    function automatic logic [31:0] wb_addr(input logic [31:0] base, input logic [9:0] word_idx);
        return base | {20'b0, word_idx, 2'b00};
    endfunction

endpackage

// File: rtl/axilite_wb_master.sv
// rtl/axilite_wb_master.sv - single-outstanding AXI-Lite slave bridged to a Wishbone master with timeout
module axilite_wb_master
    import axilite_wb_master_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int unsigned TIMEOUT   = DEF_TIMEOUT,
    parameter logic [31:0] TO_DATA   = DEF_TO_DATA
) (
    input  logic        axis_clk,
    input  logic        axis_rst_n,
    input  logic        awvalid,
    output logic        awready,
    input  logic [11:0] awaddr,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic        arvalid,
    output logic        arready,
    input  logic [11:0] araddr,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        timeout_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [31:0]       adr_q, adr_d;
    logic [31:0]       dat_q, dat_d;
    logic              we_q, we_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_was_read_q, last_was_read_d;
    logic              arready_q, arready_d;
    logic              timeout_q, timeout_d;
    logic              wr_req, rd_req, in_cyc;

    // Byte-lane bits of the AXI addresses never reach the word-addressed bus.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{awaddr[1:0], araddr[1:0]};

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q         <= IDLE;
            adr_q           <= '0;
            dat_q           <= '0;
            we_q            <= 1'b0;
            rdata_q         <= '0;
            cnt_q           <= '0;
            last_was_read_q <= 1'b0;
            arready_q       <= 1'b0;
            timeout_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            adr_q           <= adr_d;
            dat_q           <= dat_d;
            we_q            <= we_d;
            rdata_q         <= rdata_d;
            cnt_q           <= cnt_d;
            last_was_read_q <= last_was_read_d;
            arready_q       <= arready_d;
            timeout_q       <= timeout_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        adr_d           = adr_q;
        dat_d           = dat_q;
        we_d            = we_q;
        rdata_d         = rdata_q;
        cnt_d           = cnt_q;
        last_was_read_d = last_was_read_q;
        arready_d       = 1'b0;
        timeout_d       = 1'b0;
        wr_req          = awvalid & wvalid;
        rd_req          = arvalid;

        case (state_q)
            IDLE: begin
                // On a tie the read goes first unless the previous accept was a read.
                if (rd_req && (!wr_req || !last_was_read_q)) begin
                    state_d         = RD_CYC;
                    adr_d           = wb_addr(BASE_ADDR, araddr[11:2]);
                    we_d            = 1'b0;
                    cnt_d           = '0;
                    last_was_read_d = 1'b1;
                    arready_d       = 1'b1;
                end else if (wr_req) begin
                    state_d         = WR_CYC;
                    adr_d           = wb_addr(BASE_ADDR, awaddr[11:2]);
                    dat_d           = wdata;
                    we_d            = 1'b1;
                    cnt_d           = '0;
                    last_was_read_d = 1'b0;
                end
            end
            WR_CYC, RD_CYC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (wbm_ack_i) begin
                    state_d = (state_q == WR_CYC) ? WR_DONE : RD_DONE;
                    if (state_q == RD_CYC) begin
                        rdata_d = wbm_dat_i;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = (state_q == WR_CYC) ? WR_DONE : RD_DONE;
                    timeout_d = 1'b1;
                    if (state_q == RD_CYC) begin
                        rdata_d = TO_DATA;
                    end
                end
            end
            WR_DONE: state_d = IDLE;
            RD_DONE: begin
                if (rready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_cyc    = (state_q == WR_CYC) || (state_q == RD_CYC);
    assign wbm_cyc_o = in_cyc;
    assign wbm_stb_o = in_cyc;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = 4'hF;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign awready   = (state_q == WR_DONE);
    assign wready    = (state_q == WR_DONE);
    assign arready   = arready_q;
    assign rvalid    = (state_q == RD_DONE);
    assign rdata     = rdata_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_axilite_wb_master.sv
// tb/tb_axilite_wb_master.sv - directed self-checking bench for axilite_wb_master
module tb_axilite_wb_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [11:0] awaddr = '0, araddr = '0;
    logic [31:0] wdata = '0;
    logic        awready, wready, arready, rvalid;
    logic [31:0] rdata;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i, timeout_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [31:0] wbm_dat_i = '0;

    logic        ack_resp = 1'b0;
    logic        ack_spur = 1'b0;
    logic        slave_en = 1'b1;
    int          ack_wait = 0;
    int          wait_cnt = 0;
    logic [31:0] slave_data = '0;

    int n_checks = 0;
    int n_errors = 0;

    assign wbm_ack_i = ack_resp | ack_spur;

    always #5 clk = ~clk;

    axilite_wb_master dut (
        .axis_clk   (clk),
        .axis_rst_n (rst_n),
        .awvalid    (awvalid),
        .awready    (awready),
        .awaddr     (awaddr),
        .wvalid     (wvalid),
        .wready     (wready),
        .wdata      (wdata),
        .arvalid    (arvalid),
        .arready    (arready),
        .araddr     (araddr),
        .rvalid     (rvalid),
        .rready     (rready),
        .rdata      (rdata),
        .wbm_cyc_o  (wbm_cyc_o),
        .wbm_stb_o  (wbm_stb_o),
        .wbm_we_o   (wbm_we_o),
        .wbm_sel_o  (wbm_sel_o),
        .wbm_adr_o  (wbm_adr_o),
        .wbm_dat_o  (wbm_dat_o),
        .wbm_dat_i  (wbm_dat_i),
        .wbm_ack_i  (wbm_ack_i),
        .timeout_o  (timeout_o)
    );

    // Wishbone slave: acks after ack_wait wait cycles when enabled.
    initial begin
        forever begin
            @(negedge clk);
            if (wbm_cyc_o && wbm_stb_o && !ack_resp && slave_en) begin
                if (wait_cnt >= ack_wait) begin
                    ack_resp  = 1'b1;
                    wbm_dat_i = slave_data;
                end else begin
                    wait_cnt++;
                end
            end else begin
                ack_resp = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic run_write(input string tag, input logic [11:0] a, input logic [31:0] d,
                             input int waits, input logic [31:0] exp_adr);
        int n;
        ack_wait = waits;
        slave_en = 1'b1;
        awaddr   = a;
        wdata    = d;
        awvalid  = 1'b1;
        wvalid   = 1'b1;
        @(negedge clk);
        check({tag, "_cyc"}, wbm_cyc_o, 1);
        check({tag, "_stb"}, wbm_stb_o, 1);
        check({tag, "_we"}, wbm_we_o, 1);
        check({tag, "_sel"}, wbm_sel_o, 4'hF);
        check({tag, "_adr"}, wbm_adr_o, exp_adr);
        check({tag, "_dat"}, wbm_dat_o, d);
        n = 0;
        while (wbm_cyc_o && n < 300) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_cyc_len"}, n, waits + 1);
        check({tag, "_awready"}, awready, 1);
        check({tag, "_wready"}, wready, 1);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        @(negedge clk);
        check({tag, "_awready_clr"}, awready, 0);
        check({tag, "_cyc_idle"}, wbm_cyc_o, 0);
    endtask

    task automatic run_read(input string tag, input logic [11:0] a, input int waits,
                            input logic [31:0] d, input logic [31:0] exp_adr, input int rr_delay);
        int n;
        ack_wait   = waits;
        slave_en   = 1'b1;
        slave_data = d;
        rready     = 1'b0;
        araddr     = a;
        arvalid    = 1'b1;
        @(negedge clk);
        check({tag, "_cyc"}, wbm_cyc_o, 1);
        check({tag, "_we"}, wbm_we_o, 0);
        check({tag, "_adr"}, wbm_adr_o, exp_adr);
        check({tag, "_arready"}, arready, 1);
        arvalid = 1'b0;
        n = 0;
        while (wbm_cyc_o && n < 300) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_cyc_len"}, n, waits + 1);
        check({tag, "_arready_clr"}, arready, 0);
        for (int i = 0; i < rr_delay; i++) begin
            check({tag, "_rvalid_hold"}, rvalid, 1);
            check({tag, "_rdata_hold"}, rdata, d);
            @(negedge clk);
        end
        rready = 1'b1;
        check({tag, "_rvalid"}, rvalid, 1);
        check({tag, "_rdata"}, rdata, d);
        @(negedge clk);
        rready = 1'b0;
        check({tag, "_rvalid_clr"}, rvalid, 0);
    endtask

    initial begin
        int n;
        int cnt;
        int round;
        logic prev_cyc;
        logic we_seq[$];
        int starts[$];

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_cyc", wbm_cyc_o, 0);
        check("rst_stb", wbm_stb_o, 0);
        check("rst_we", wbm_we_o, 0);
        check("rst_sel", wbm_sel_o, 4'hF);
        check("rst_adr", wbm_adr_o, 0);
        check("rst_dat", wbm_dat_o, 0);
        check("rst_rdy", {awready, wready, arready, rvalid, timeout_o}, 0);
        check("rst_rdata", rdata, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Simultaneous requests twice: read wins first after reset, then alternates
        ack_wait   = 0;
        slave_en   = 1'b1;
        slave_data = 32'h0000_0055;
        rready     = 1'b1;
        awaddr     = 12'h020;
        wdata      = 32'h0000_0011;
        araddr     = 12'h040;
        awvalid    = 1'b1;
        wvalid     = 1'b1;
        arvalid    = 1'b1;
        round      = 1;
        prev_cyc   = 1'b0;
        for (int t = 0; t < 60 && we_seq.size() < 4; t++) begin
            @(negedge clk);
            if (wbm_cyc_o && !prev_cyc) begin
                we_seq.push_back(wbm_we_o);
                starts.push_back(t);
            end
            prev_cyc = wbm_cyc_o;
            if (arready) begin
                arvalid = 1'b0;
            end else if (awready) begin
                awvalid = 1'b0;
                wvalid  = 1'b0;
            end else if (!arvalid && !awvalid && round < 2) begin
                awvalid = 1'b1;
                wvalid  = 1'b1;
                arvalid = 1'b1;
                round++;
            end
        end
        check("arb_count", we_seq.size(), 4);
        if (we_seq.size() == 4) begin
            check("arb_0_read", we_seq[0], 0);
            check("arb_1_write", we_seq[1], 1);
            check("arb_2_read", we_seq[2], 0);
            check("arb_3_write", we_seq[3], 1);
            check("b2b_spacing", starts[1] - starts[0], 3);
        end
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (arready) arvalid = 1'b0;
            if (awready) begin
                awvalid = 1'b0;
                wvalid  = 1'b0;
            end
        end
        rready = 1'b0;

        // Write with two wait states
        run_write("wr36", 12'h010, 32'h0000_00A5, 2, 32'h3000_0010);

        // Zero-wait read with rready held off three cycles
        run_read("rd37", 12'h084, 0, 32'h1234_5678, 32'h3000_0084, 3);

        // Lone awvalid is held off until wvalid joins
        awaddr  = 12'h030;
        awvalid = 1'b1;
        cnt     = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (wbm_cyc_o || awready) cnt++;
        end
        check("lone_aw_no_cyc", cnt, 0);
        run_write("wr40", 12'h030, 32'h0000_0077, 0, 32'h3000_0030);

        // Stray ack while idle is ignored
        ack_spur = 1'b1;
        cnt = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (wbm_cyc_o || awready || rvalid) cnt++;
        end
        ack_spur = 1'b0;
        check("spur_ack_ignored", cnt, 0);
        run_read("rd29", 12'h00B, 1, 32'h0BAD_CAFE, 32'h3000_0008, 0);

        // Read timeout: no ack
        slave_en = 1'b0;
        araddr   = 12'h100;
        arvalid  = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        n   = 0;
        cnt = 0;
        while (wbm_cyc_o && n < 400) begin
            n++;
            if (timeout_o) cnt++;
            @(negedge clk);
        end
        check("to_cyc_len", n, 255);
        check("to_no_early_pulse", cnt, 0);
        check("to_pulse", timeout_o, 1);
        check("to_rvalid", rvalid, 1);
        check("to_rdata", rdata, 32'hDEAD_BEEF);
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        check("to_pulse_clr", timeout_o, 0);
        check("to_rvalid_clr", rvalid, 0);

        // Reset in the middle of a read cycle
        slave_en = 1'b0;
        araddr   = 12'h200;
        arvalid  = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_rst_in_cyc", wbm_cyc_o, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_cyc", wbm_cyc_o, 0);
        check("mid_rst_stb", wbm_stb_o, 0);
        check("mid_rst_rvalid", rvalid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", {wbm_cyc_o, rvalid, arready}, 0);
        run_write("wr41", 12'h0FF, 32'hCAFE_F00D, 1, 32'h3000_00FC);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axilite_wb_master.md
AXILITE_WB_MASTER -- requirements
Module: axilite_wb_master

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000: Wishbone base address OR-ed with the AXI-Lite word offset.
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum Wishbone wait cycles before forced completion.
REQ-003 SHALL have parameter TO_DATA, default 32'hDEAD_BEEF: read data returned on timeout.
REQ-004 axis_clk  input  1  the single clock; all logic on its rising edge.
REQ-005 axis_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 awvalid/awready  input/output  1/1  AXI-Lite write-address handshake.
REQ-007 awaddr  input  12  write byte address.
REQ-008 wvalid/wready  input/output  1/1  AXI-Lite write-data handshake.
REQ-009 wdata  input  32  write data.
REQ-010 arvalid/arready  input/output  1/1  AXI-Lite read-address handshake.
REQ-011 araddr  input  12  read byte address.
REQ-012 rvalid/rready  output/input  1/1  AXI-Lite read-data handshake.
REQ-013 rdata  output  32  read data.
REQ-014 wbm_cyc_o, wbm_stb_o, wbm_we_o  output  1 each  Wishbone master cycle, strobe and write enable.
REQ-015 wbm_sel_o  output  4  byte selects; always 4'hF.
REQ-016 wbm_adr_o  output  32  BASE_ADDR | {20'b0, addr[11:2], 2'b00}.
REQ-017 wbm_dat_o / wbm_dat_i  output/input  32/32  Wishbone write/read data.
REQ-018 wbm_ack_i  input  1  Wishbone acknowledge.
REQ-019 timeout_o  output  1  one-cycle pulse when a Wishbone cycle is force-terminated.

Function
REQ-020 SHALL implement FSM states IDLE, WR_CYC, WR_DONE, RD_CYC, RD_DONE.
REQ-021 In IDLE, awvalid&wvalid both high SHALL be a write request; arvalid high SHALL be a read request; a lone awvalid or wvalid SHALL be held off.
REQ-022 With write and read requested in the same cycle, priority SHALL alternate via a last_was_read flag; after reset the read wins first.
REQ-023 Request accepted in IDLE at edge N -> wbm_cyc_o=wbm_stb_o=1 from cycle N+1, with address, data and we registered at N.
REQ-024 cyc/stb SHALL stay high until wbm_ack_i sampled high, or until the timeout counter reaches TIMEOUT.
REQ-025 Write ack at edge M -> cyc/stb low and awready=wready=1 for exactly one cycle (WR_DONE) in M+1, then IDLE.
REQ-026 arready SHALL pulse for one cycle in the cycle after read acceptance; the arvalid request is thus consumed once.
REQ-027 Read ack at edge M -> rdata<=wbm_dat_i captured at M; rvalid=1 from M+1 (RD_DONE), held with stable rdata until rready sampled high; IDLE next cycle.
REQ-028 Timeout counter SHALL clear on every acceptance and increment each cycle in WR_CYC/RD_CYC; at TIMEOUT the cycle ends, timeout_o pulses, a read returns TO_DATA, and a write completes as in REQ-025.
REQ-029 A wbm_ack_i outside WR_CYC/RD_CYC SHALL be ignored.
REQ-030 Back-to-back: new request SHALL be accepted no earlier than the cycle after WR_DONE/RD_DONE exit; minimum 3 cycles per transaction with zero-wait ack.
REQ-031 awaddr/araddr bits [1:0] SHALL be ignored.

Reset
REQ-032 axis_rst_n low SHALL asynchronously force IDLE; all outputs 0 except wbm_sel_o=4'hF; rdata=0; counter=0; last_was_read=0.
REQ-033 Reset mid-transaction SHALL abort it with no response; first request after release is handled normally.

Structure
REQ-034 Shared package SHALL hold the state enum, default BASE_ADDR, TIMEOUT and TO_DATA constants.
REQ-035 Single module; no sub-module; timeout counter inline, width clog2(TIMEOUT+1).

Verification
REQ-036 Write awaddr=12'h010, wdata=32'h0000_00A5, ack after 2 waits -> wbm_adr_o=32'h3000_0010, wbm_dat_o=32'hA5, we=1, awready/wready one-cycle pulse after ack.
REQ-037 Read araddr=12'h084, slave returns 32'h1234_5678 zero-wait, rready low 3 cycles -> rvalid held 4 cycles, rdata stable 32'h1234_5678.
REQ-038 Simultaneous write and read requests twice in a row -> read, write, read, write order.
REQ-039 Read with no ack -> cyc low after 255 wait cycles, timeout_o one pulse, rdata=32'hDEAD_BEEF.
REQ-040 awvalid alone 10 cycles, then wvalid -> no Wishbone cycle until both high.
REQ-041 axis_rst_n low during RD_CYC -> cyc/stb/rvalid 0 immediately; next write completes correctly.
